// File: rtl/jump_target_table.sv
// Writable jump-target table with absolute/PC-relative lookup and a small
// return-address stack for call/return, feeding the fetch stage's next-PC mux.
module jump_target_table #(
  parameter int D = 12,
  parameter int A = 4,
  parameter int S = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [A-1:0] addr_i,
  input  logic         rel_i,
  input  logic [D-1:0] pc_i,
  output logic [D-1:0] target_o,
  input  logic         wr_en_i,
  input  logic [A-1:0] wr_addr_i,
  input  logic [D-1:0] wr_data_i,
  input  logic         push_i,
  input  logic         pop_i,
  output logic [D-1:0] ret_addr_o,
  output logic         ras_empty_o,
  output logic         ras_full_o,
  output logic         ras_err_o
);

  localparam int CW = $clog2(S + 1);
  localparam int TD = 2 ** A;

  logic [D-1:0]  tbl_q   [TD];
  logic [D-1:0]  stack_q [S];
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          stackWe;
  logic [CW-1:0] stackWIdx;
  logic [CW-1:0] topIdx;
  logic [D-1:0]  pcInc;
  logic [D-1:0]  entry;
  logic          isEmpty, isFull;

  assign pcInc   = pc_i + D'(1);
  assign topIdx  = count_q - CW'(1);
  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == CW'(S));
  assign entry   = tbl_q[addr_i];

  // Reads come straight from the registers, so a same-cycle write stays invisible.
  assign target_o    = rel_i ? (pc_i + entry) : entry;
  assign ret_addr_o  = isEmpty ? '0 : stack_q[topIdx];
  assign ras_empty_o = isEmpty;
  assign ras_full_o  = isFull;
  assign ras_err_o   = err_q;

  always_comb begin
    count_d   = count_q;
    err_d     = err_q;
    stackWe   = 1'b0;
    stackWIdx = count_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (isFull) begin
          err_d = 1'b1;
        end else begin
          stackWe = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (isEmpty) err_d = 1'b1;
        else         count_d = topIdx;
      end
      2'b11: begin
        // Simultaneous call/return on an empty stack degenerates into a plain push.
        stackWe = 1'b1;
        if (isEmpty) count_d = count_q + CW'(1);
        else         stackWIdx = topIdx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < TD; i++) tbl_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_en_i) tbl_q[wr_addr_i] <= wr_data_i;
      if (stackWe) stack_q[stackWIdx] <= pcInc;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_jump_target_table.sv
// Scoreboard bench for jump_target_table: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_jump_target_table;

  localparam int D = 12;
  localparam int A = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [A-1:0] addr;
  logic         rel;
  logic [D-1:0] pc;
  logic [D-1:0] target;
  logic         wrEn;
  logic [A-1:0] wrAddr;
  logic [D-1:0] wrData;
  logic         push;
  logic         pop;
  logic [D-1:0] retAddr;
  logic         rasEmpty;
  logic         rasFull;
  logic         rasErr;

  typedef struct {
    string        name;
    logic [4:0]   mask;
    logic [D-1:0] tgt;
    logic [D-1:0] ret;
    logic         empty;
    logic         full;
    logic         err;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  jump_target_table #(.D(D), .A(A), .S(S)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .addr_i     (addr),
    .rel_i      (rel),
    .pc_i       (pc),
    .target_o   (target),
    .wr_en_i    (wrEn),
    .wr_addr_i  (wrAddr),
    .wr_data_i  (wrData),
    .push_i     (push),
    .pop_i      (pop),
    .ret_addr_o (retAddr),
    .ras_empty_o(rasEmpty),
    .ras_full_o (rasFull),
    .ras_err_o  (rasErr)
  );

  always #5 clk = ~clk;

  // mask bits: 0 target, 1 ret_addr, 2 ras_empty, 3 ras_full, 4 ras_err
  localparam logic [4:0] M_TGT = 5'b00001;
  localparam logic [4:0] M_RAS = 5'b11110;
  localparam logic [4:0] M_ALL = 5'b11111;

  task automatic checkOutput(input string what, input logic [D-1:0] act, input logic [D-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each queued entry is checked mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      if (e.mask[0]) checkOutput({e.name, ".target"}, target, e.tgt);
      if (e.mask[1]) checkOutput({e.name, ".ret_addr"}, retAddr, e.ret);
      if (e.mask[2]) checkOutput({e.name, ".ras_empty"}, D'(rasEmpty), D'(e.empty));
      if (e.mask[3]) checkOutput({e.name, ".ras_full"}, D'(rasFull), D'(e.full));
      if (e.mask[4]) checkOutput({e.name, ".ras_err"}, D'(rasErr), D'(e.err));
    end
  end

  task automatic applyStimulus(
    input logic rst, input logic [A-1:0] ad, input logic rl, input logic [D-1:0] p,
    input logic we, input logic [A-1:0] wa, input logic [D-1:0] wd,
    input logic pu, input logic po,
    input string name, input logic [4:0] mask,
    input logic [D-1:0] eTgt, input logic [D-1:0] eRet,
    input logic eEmpty, input logic eFull, input logic eErr);
    expT e;
    @(posedge clk);
    #1;
    reset  = rst;
    addr   = ad;
    rel    = rl;
    pc     = p;
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    push   = pu;
    pop    = po;
    if (mask != '0) begin
      e.name  = name;
      e.mask  = mask;
      e.tgt   = eTgt;
      e.ret   = eRet;
      e.empty = eEmpty;
      e.full  = eFull;
      e.err   = eErr;
      expQ.push_back(e);
    end
  endtask

  initial begin
    int waitCycles;
    reset = 1'b1; addr = '0; rel = 1'b0; pc = '0;
    wrEn = 1'b0; wrAddr = '0; wrData = '0; push = 1'b0; pop = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst", 5'b0, 0, 0, 0, 0, 0);

    // 1: reset contents
    for (int i = 0; i < 16; i++)
      applyStimulus(0, A'(i), 0, 12'h123, 0, 0, 0, 0, 0, $sformatf("sweep%0d", i),
                    M_ALL, 12'h000, 12'h000, 1, 0, 0);
    applyStimulus(0, 0, 1, 12'h123, 0, 0, 0, 0, 0, "relReset", M_TGT, 12'h123, 0, 0, 0, 0);

    // 2: write without write-through
    applyStimulus(0, 3, 0, 0, 1, 3, 12'd54, 0, 0, "wrSame", M_TGT, 12'd0, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 0, "wrNext", M_TGT, 12'd54, 0, 0, 0, 0);

    // 3: relative targets with negative offsets
    applyStimulus(0, 5, 1, 12'd4, 1, 5, 12'hFFF, 0, 0, "relOld", M_TGT, 12'd4, 0, 0, 0, 0);
    applyStimulus(0, 5, 1, 12'd4, 1, 6, 12'hFFB, 0, 0, "relM1", M_TGT, 12'd3, 0, 0, 0, 0);
    applyStimulus(0, 6, 1, 12'd4, 0, 0, 0, 0, 0, "relM5", M_TGT, 12'hFFF, 0, 0, 0, 0);
    applyStimulus(0, 6, 0, 12'd4, 0, 0, 0, 0, 0, "absM5", M_TGT, 12'hFFB, 0, 0, 0, 0);

    // 4: fill, overflow, drain
    applyStimulus(0, 0, 0, 12'd10, 0, 0, 0, 1, 0, "push10", M_RAS, 0, 12'd0,  1, 0, 0);
    applyStimulus(0, 0, 0, 12'd20, 0, 0, 0, 1, 0, "push20", M_RAS, 0, 12'd11, 0, 0, 0);
    applyStimulus(0, 0, 0, 12'd30, 0, 0, 0, 1, 0, "push30", M_RAS, 0, 12'd21, 0, 0, 0);
    applyStimulus(0, 0, 0, 12'd40, 0, 0, 0, 1, 0, "push40", M_RAS, 0, 12'd31, 0, 0, 0);
    applyStimulus(0, 0, 0, 12'd50, 0, 0, 0, 1, 0, "push50", M_RAS, 0, 12'd41, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "pop1", M_RAS, 0, 12'd41, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "pop2", M_RAS, 0, 12'd31, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "pop3", M_RAS, 0, 12'd21, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "pop4", M_RAS, 0, 12'd11, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "drained", M_RAS, 0, 12'd0, 1, 0, 1);

    // 5: replace top, then underflow
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst2", 5'b0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 12'd10, 0, 0, 0, 1, 0, "push10b", M_RAS, 0, 12'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 12'd99, 0, 0, 0, 1, 1, "pushPop", M_RAS, 0, 12'd11, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "popRepl", M_RAS, 0, 12'd100, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "popEmpty", M_RAS, 0, 12'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "underflow", M_RAS, 0, 12'd0, 1, 0, 1);

    // 6: reset discards same-cycle push/write
    applyStimulus(1, 0, 0, 12'd7, 1, 2, 12'd9, 1, 0, "rstPush", 5'b0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0, 0, 0, 0, 0, "afterRst", M_ALL, 12'd0, 12'd0, 1, 0, 0);
    applyStimulus(0, 3, 0, 12'hFFF, 0, 0, 0, 1, 0, "tblClr", M_ALL, 12'd0, 12'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "wrapPush", M_RAS, 0, 12'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 12'd5, 0, 0, 0, 1, 1, "ppEmpty", M_RAS, 0, 12'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "ppAsPush", M_RAS, 0, 12'd6, 0, 0, 0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
